// File: rtl/thresholding_pkg.sv
// Shared types and helpers for the thresholding core configuration path.
// Combinational definitions only; no latency.
// No flow control here; used by the loader and its bench.
package thresholding_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } loader_state_e;

  // Bit positions inside the sticky error vector
  localparam int ERR_ORDER = 0;
  localparam int ERR_LAST  = 1;

  // Thresholds per channel for an N-bit output core
  function automatic int thresh_count(input int n);
    return (1 << n) - 1;
  endfunction

endpackage

// File: rtl/thresholding_loader_if.sv
// Ready/valid threshold stream from the host/DMA side into the loader.
// Wires only; no latency.
// Beat transfers when s_tvalid and s_tready are both high.
interface thresholding_loader_if #(
  parameter int M = 8
) ();

  logic         s_tvalid;
  logic         s_tready;
  logic [M-1:0] s_tdata;
  logic         s_tlast;

  modport master (output s_tvalid, output s_tdata, output s_tlast, input s_tready);
  modport slave  (input s_tvalid, input s_tdata, input s_tlast, output s_tready);

endinterface

// File: rtl/thresholding_loader.sv
// Streams C*(2^N-1) signed thresholds into the core's twe/twa/twd port, checking order and tlast.
// One cycle: a handshake in cycle t gives the registered write in cycle t+1.
// s_tready is high only in LOAD and depends on state alone; no internal buffering.
module thresholding_loader
  import thresholding_pkg::*;
#(
  parameter int N = 4,
  parameter int M = 8,
  parameter int C = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  thresholding_loader_if.slave     s_axis,
  output logic                     twe,
  output logic [$clog2(C)+N-1:0]   twa,
  output logic [M-1:0]             twd,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               err
);

  localparam int CW       = (C > 1) ? $clog2(C) : 1;
  localparam int AW       = $clog2(C) + N;
  localparam int IDX_LAST = thresh_count(N) - 1;

  loader_state_e r_state, w_state_nxt;
  logic [CW-1:0] r_cnl;
  logic [N-1:0]  r_idx;
  logic [M-1:0]  r_prev;
  logic          r_twe;
  logic [AW-1:0] r_twa;
  logic [M-1:0]  r_twd;
  logic [1:0]    r_err;

  logic          w_hs;
  logic          w_start_ok;
  logic          w_idx_last;
  logic          w_final;
  logic          w_early_last;
  logic          w_order_bad;
  logic [AW-1:0] w_addr;

  assign s_axis.s_tready = (r_state == LOAD);
  assign w_hs            = s_axis.s_tvalid && (r_state == LOAD);
  assign w_start_ok      = start && (r_state != LOAD);
  assign w_idx_last      = (r_idx == N'(IDX_LAST));
  assign w_final         = w_idx_last && (r_cnl == CW'(C - 1));
  assign w_early_last    = s_axis.s_tlast && !w_final;
  // Each channel starts fresh, so index 0 is never compared against the previous channel
  assign w_order_bad     = w_hs && (r_idx != '0) &&
                           ($signed(s_axis.s_tdata) <= $signed(r_prev));

  generate
    if (C > 1) begin : g_multi_ch
      assign w_addr = {r_cnl, r_idx};
    end else begin : g_single_ch
      assign w_addr = r_idx;
    end
  endgenerate

  assign twe  = r_twe;
  assign twa  = r_twa;
  assign twd  = r_twd;
  assign err  = r_err;
  assign done = (r_state == DONE);
  assign busy = (r_state == LOAD) || r_twe;

  // Next-state decode: start leaves any idle state, the terminating beat picks DONE or ERROR
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE, DONE, ERROR: begin
        if (start) w_state_nxt = LOAD;
      end
      LOAD: begin
        if (w_hs) begin
          if (w_early_last) begin
            w_state_nxt = ERROR;
          end else if (w_final) begin
            if (!s_axis.s_tlast || r_err[ERR_ORDER] || w_order_bad) w_state_nxt = ERROR;
            else w_state_nxt = DONE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Counters, order tracking, sticky errors and the registered write port
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnl  <= '0;
      r_idx  <= '0;
      r_prev <= '0;
      r_twe  <= 1'b0;
      r_twa  <= '0;
      r_twd  <= '0;
      r_err  <= '0;
    end else begin
      r_twe <= 1'b0;
      if (w_start_ok) begin
        r_cnl  <= '0;
        r_idx  <= '0;
        r_prev <= '0;
        r_err  <= '0;
      end else if (w_hs) begin
        if (w_early_last) begin
          // Beat is swallowed: the core must not see a partial set as complete
          r_err[ERR_LAST] <= 1'b1;
        end else begin
          r_twe  <= 1'b1;
          r_twa  <= w_addr;
          r_twd  <= s_axis.s_tdata;
          r_prev <= s_axis.s_tdata;
          if (w_order_bad) r_err[ERR_ORDER] <= 1'b1;
          if (w_final && !s_axis.s_tlast) r_err[ERR_LAST] <= 1'b1;
          if (w_idx_last) begin
            r_idx <= '0;
            r_cnl <= r_cnl + 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_thresholding_loader.sv
// Directed bench for thresholding_loader (N=2, M=8, C=2) with a write scoreboard.
// Expected writes are queued one cycle after each accepted beat and checked as twe appears.
// Covers clean, gapped, order-error, early/missing tlast and mid-load reset sequences.
module tb_thresholding_loader;

  localparam int N  = 2;
  localparam int M  = 8;
  localparam int C  = 2;
  localparam int AW = 3;

  typedef struct {
    int          addr;
    logic [7:0]  data;
    int          cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          twe;
  logic [AW-1:0] twa;
  logic [M-1:0]  twd;
  logic          busy;
  logic          done;
  logic [1:0]    err;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  exp_t sb[$];

  thresholding_loader_if #(.M(M)) s_if ();

  thresholding_loader #(.N(N), .M(M), .C(C)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .s_axis(s_if.slave),
    .twe   (twe),
    .twa   (twa),
    .twd   (twd),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Write monitor: every twe must match the oldest queued beat, in the cycle after its handshake
  always @(negedge clk) begin
    exp_t e;
    if (twe === 1'b1) begin
      if (sb.size() == 0) begin
        check("twe_unexpected", 32'(twe), 32'd0);
      end else begin
        e = sb.pop_front();
        check("twa", 32'(twa), 32'(e.addr));
        check("twd", 32'(twd), 32'(e.data));
        check("twe_cycle", 32'(cyc), 32'(e.cyc));
      end
    end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
      check("twe_missing", 32'(twe), 32'd1);
      void'(sb.pop_front());
    end
  end

  task automatic send(input int d, input bit last, input bit wr, input int addr);
    bit ok;
    ok = 1'b0;
    s_if.s_tvalid = 1'b1;
    s_if.s_tdata  = 8'(d);
    s_if.s_tlast  = last;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = (s_if.s_tready === 1'b1);
    end
    if (!ok) check("hs_timeout", 32'(s_if.s_tready), 32'd1);
    @(posedge clk); #1;
    if (ok && wr) sb.push_back('{addr, 8'(d), cyc});
    s_if.s_tvalid = 1'b0;
    s_if.s_tlast  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  function automatic int addr_of(input int i);
    return (i / 3) * 4 + (i % 3);
  endfunction

  // Full 6-beat set; last_idx is the beat carrying tlast (-1 for none)
  task automatic run_stream(input int d[6], input int last_idx, input bit gaps);
    for (int i = 0; i < 6; i++) begin
      send(d[i], (i == last_idx), !((i == last_idx) && (i != 5)), addr_of(i));
      if (gaps && i != 5) begin
        @(posedge clk); #1;
      end
    end
  endtask

  // Final-write cycle then the settled cycle after it
  task automatic end_checks(input string tag, input logic exp_done, input logic [1:0] exp_err);
    @(negedge clk);
    check({tag, "_done_final"}, 32'(done), 32'(exp_done));
    check({tag, "_busy_final"}, 32'(busy), 32'd1);
    @(negedge clk);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_done_after"}, 32'(done), 32'(exp_done));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_tready"}, 32'(s_if.s_tready), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_twe"}, 32'(twe), 32'd0);
    check({tag, "_twa"}, 32'(twa), 32'd0);
    check({tag, "_twd"}, 32'(twd), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_tready"}, 32'(s_if.s_tready), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    s_if.s_tvalid = 1'b0;
    s_if.s_tdata  = '0;
    s_if.s_tlast  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Clean load; a beat offered alongside start must be ignored
    start = 1'b1;
    s_if.s_tvalid = 1'b1;
    s_if.s_tdata  = 8'hAA;
    @(negedge clk);
    check("tready_during_start", 32'(s_if.s_tready), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    s_if.s_tvalid = 1'b0;
    @(negedge clk);
    check("tready_in_load", 32'(s_if.s_tready), 32'd1);
    check("busy_in_load", 32'(busy), 32'd1);
    check("twe_after_start", 32'(twe), 32'd0);
    @(posedge clk); #1;
    run_stream('{-5, 0, 7, 1, 2, 3}, 5, 1'b0);
    end_checks("clean", 1'b1, 2'b00);

    // Same stream with one idle cycle between beats
    pulse_start();
    @(negedge clk);
    check("done_cleared_by_start", 32'(done), 32'd0);
    @(posedge clk); #1;
    run_stream('{-5, 0, 7, 1, 2, 3}, 5, 1'b1);
    end_checks("gaps", 1'b1, 2'b00);

    // Order violation in channel 0; channel 1 starting at -128 is legal
    pulse_start();
    run_stream('{4, 4, 9, -128, 2, 3}, 5, 1'b0);
    end_checks("order", 1'b0, 2'b01);

    // tlast on beat 3: only two writes
    pulse_start();
    send(1, 1'b0, 1'b1, 0);
    send(2, 1'b0, 1'b1, 1);
    send(3, 1'b1, 1'b0, 2);
    @(negedge clk);
    @(negedge clk);
    check("early_err", 32'(err), 32'd2);
    check("early_tready", 32'(s_if.s_tready), 32'd0);
    check("early_done", 32'(done), 32'd0);
    check("early_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    pulse_start();
    run_stream('{-5, 0, 7, 1, 2, 3}, 5, 1'b0);
    end_checks("recover", 1'b1, 2'b00);

    // No tlast on the final beat; a 7th beat is refused
    pulse_start();
    run_stream('{10, 20, 30, 40, 50, 60}, -1, 1'b0);
    end_checks("nolast", 1'b0, 2'b10);
    s_if.s_tvalid = 1'b1;
    s_if.s_tdata  = 8'd70;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("nolast_7th_tready", 32'(s_if.s_tready), 32'd0);
    end
    @(posedge clk); #1;
    s_if.s_tvalid = 1'b0;

    // Reset after beat 2 of a load
    pulse_start();
    send(-1, 1'b0, 1'b1, 0);
    send(5, 1'b0, 1'b1, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");
    @(negedge clk);
    check("midrst_tready_idle", 32'(s_if.s_tready), 32'd0);
    @(posedge clk); #1;
    pulse_start();
    run_stream('{-5, 0, 7, 1, 2, 3}, 5, 1'b0);
    end_checks("after_rst", 1'b1, 2'b00);

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
